// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//
// Shares one in-order memory read port between the instruction-fetch
// requester (I) and the data-load requester (D). Every accepted read is
// recorded in a small route FIFO (owner + drop flag), so each in-order
// memory response can be steered back to the side that issued it. A fetch
// flush marks all queued I entries as dropped, which makes their responses
// disappear silently when they return.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - when both sides request, alternate grants using a
//                        one-bit last-grant register (D goes first after reset).
//                        Left undefined, D always has priority over I.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_addr/i_avalid     fetch request;  i_aready = fetch request accepted
//   i_valid/i_data      fetch response
//   i_flush             drop all in-flight and current-cycle fetch traffic
//   d_addr/d_avalid     load request;   d_aready = load request accepted
//   d_valid/d_data      load response
//   m_addr/m_avalid     memory request; m_aready = memory accepts
//   m_valid/m_data      memory response (returned in request order)
//   err                 sticky: response seen with no outstanding request

module mem_read_arbiter #(
  parameter int ADDR_BITS       = 32,
  parameter int DATA_BITS       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic                 i_avalid,
  output logic                 i_aready,
  output logic                 i_valid,
  output logic [DATA_BITS-1:0] i_data,
  input  logic                 i_flush,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic                 d_avalid,
  output logic                 d_aready,
  output logic                 d_valid,
  output logic [DATA_BITS-1:0] d_data,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic                 m_avalid,
  input  logic                 m_aready,
  input  logic                 m_valid,
  input  logic [DATA_BITS-1:0] m_data,
  output logic                 err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]           count;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [MAX_OUTSTANDING-1:0] own_d;
  logic [MAX_OUTSTANDING-1:0] drop;
  logic                       err_q;

  logic i_elig;
  logic d_elig;
  logic full;
  logic grant_i;
  logic grant_d;
  logic accept;
  logic pop;
  logic head_own_d;
  logic head_drop;

  // Depth is a power of two, so natural pointer overflow gives the wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // A flushed fetch request is not eligible in the flush cycle itself.
  assign i_elig = i_avalid & ~i_flush;
  assign d_elig = d_avalid;

  // Full is judged on the registered count only: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign full = (count == FULL_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  // last_d = 1 means D won the most recent accepted grant. Reset value 0
  // lets D win the first contended cycle.
  logic last_d;

  always_comb begin
    grant_d = d_elig & (~i_elig | ~last_d);
    grant_i = i_elig & (~d_elig |  last_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (accept) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_elig;
  assign grant_i = i_elig & ~d_elig;
`endif

  assign head_own_d = own_d[rd_ptr];
  assign head_drop  = drop[rd_ptr];

  // Request and response paths are purely combinational; everything is
  // gated by rst_n so the block is silent while held in reset.
  always_comb begin
    m_avalid = rst_n & (i_elig | d_elig) & ~full;
    m_addr   = grant_i ? i_addr : d_addr;
    accept   = m_avalid & m_aready;
    i_aready = accept & grant_i;
    d_aready = accept & grant_d;
    pop      = rst_n & m_valid & (count != '0);
    d_valid  = pop & head_own_d;
    // An I response is suppressed if its entry was flushed earlier or a
    // flush is arriving in this very cycle.
    i_valid  = pop & ~head_own_d & ~head_drop & ~i_flush;
    i_data   = m_data;
    d_data   = m_data;
    err      = err_q;
  end

  // The owner bit is only read for occupied slots, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      own_d[wr_ptr] <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= '0;
      err_q  <= 1'b0;
    end else begin
      // Flush marks every I slot; stale slots marked here are harmless
      // because a push always rewrites the drop bit. No I push can happen
      // in a flush cycle, so the two writes never target the same entry.
      if (i_flush) begin
        drop <= drop | ~own_d;
      end
      if (accept) begin
        drop[wr_ptr] <= 1'b0;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (m_valid && (count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares one in-order memory read port between the instruction-fetch requester (I) and the data-load requester (D). It tracks up to MAX_OUTSTANDING accepted reads in a route FIFO, steers each in-order response back to its owner, and discards instruction responses invalidated by a fetch flush (branch mispredict). It sits between the core's fetch/load units and the memory read interface.

## Interface
- ADDR_BITS, 32, address width
- DATA_BITS, 32, read data width
- MAX_OUTSTANDING, 4, route FIFO depth; power of two, ≥2
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_addr  in  ADDR_BITS  fetch read address
- i_avalid  in  1  fetch request valid
- i_aready  out  1  fetch request accepted this cycle
- i_valid  out  1  fetch response valid
- i_data  out  DATA_BITS  fetch response data
- i_flush  in  1  discard all in-flight and current-cycle fetch requests/responses
- d_addr  in  ADDR_BITS  load read address
- d_avalid  in  1  load request valid
- d_aready  out  1  load request accepted this cycle
- d_valid  out  1  load response valid
- d_data  out  DATA_BITS  load response data
- m_addr  out  ADDR_BITS  memory read address
- m_avalid  out  1  memory request valid
- m_aready  in  1  memory accepts request
- m_valid  in  1  memory response valid (in request order)
- m_data  in  DATA_BITS  memory response data
- err  out  1  sticky protocol error: m_valid seen with empty route FIFO

## Operation
- Eligible requests: I when i_avalid & !i_flush; D when d_avalid.
- full = (count == MAX_OUTSTANDING), from registered count only; no push while full, even if a pop occurs that cycle.
- Grant: one eligible requester per cycle (policy in Configuration). m_avalid = any eligible & !full; m_addr = granted address (D address when none eligible).
- Accept = m_avalid & m_aready; only the granted side's aready = accept; other side's aready = 0.
- On accept: push entry {owner, drop=0} at wr pointer; wr pointer increments mod MAX_OUTSTANDING.
- On m_valid with count>0: pop head; rd pointer increments mod MAX_OUTSTANDING. owner=D → d_valid=1. owner=I and drop=0 and !i_flush → i_valid=1. Otherwise response consumed silently.
- i_data and d_data both carry m_data whenever m_valid; only the valid flags are steered.
- i_flush: sets drop on every queued owner=I entry; response popped in the flush cycle is also suppressed; I request blocked that cycle. D traffic unaffected.
- count: +1 on accept, −1 on valid pop, unchanged when both.
- m_valid with count==0: no pop, no output valid, err ← 1 (cleared only by reset).

## Timing
- Grant, aready, m_avalid, m_addr: combinational, zero-cycle request path.
- Response steering: combinational, m_valid → i_valid/d_valid same cycle.
- Accept at edge N: entry visible from cycle N+1; pairing response may arrive from cycle N+1.
- Flush at edge N: drop bits effective from cycle N+1; current cycle suppressed combinationally.
- Reset: count=0, pointers=0, all drop bits=0, err=0, round-robin pointer favours D. During rst_n=0: m_avalid=0, i_aready=0, d_aready=0, i_valid=0, d_valid=0. Reset mid-operation discards all tracked entries; responses arriving after reset are errors.

## Configuration
- ARB_ROUND_ROBIN_EN defined: one-bit last-grant register; when both eligible, grant the side not granted last; updates only on accept; reset value selects D first.
- Undefined: fixed priority, D always wins over I; no last-grant register.

## Test plan
- Single D read 0x100, m_aready=1, response 0xDEADBEEF next cycle → d_valid=1, d_data=0xDEADBEEF, i_valid=0, count returns to 0.
- I and D both requesting continuously, m_aready=1: fixed mode → D granted every cycle; ARB_ROUND_ROBIN_EN → grants alternate D,I,D,I starting with D.
- 4 I reads accepted, no responses → m_avalid=0 and i_aready=0 while count=4; a pop in that cycle does not allow a push until next cycle.
- Issue I,I,D, assert i_flush one cycle, then return 3 responses → i_valid stays 0, single d_valid=1 on third response, count=0.
- i_flush coincident with m_valid for I head entry and i_avalid=1 → i_valid=0, i_aready=0, entry popped.
- m_valid=1 with empty FIFO → no valid outputs, err=1 until rst_n=0.
